// File: rtl/data_mem_access_unit_if.sv
// Word-wide data memory bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface data_mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  MEM_REQ_READ;
  logic                  MEM_REQ_WRITE;
  logic [ADDR_WIDTH-3:0] MEM_ADDR;
  logic [31:0]           MEM_WDATA;
  logic [3:0]            MEM_BYTE_EN;
  logic [31:0]           MEM_RDATA;
  logic                  MEM_ACK;

  modport master (
    output MEM_REQ_READ,
    output MEM_REQ_WRITE,
    output MEM_ADDR,
    output MEM_WDATA,
    output MEM_BYTE_EN,
    input  MEM_RDATA,
    input  MEM_ACK
  );

  modport slave (
    input  MEM_REQ_READ,
    input  MEM_REQ_WRITE,
    input  MEM_ADDR,
    input  MEM_WDATA,
    input  MEM_BYTE_EN,
    output MEM_RDATA,
    output MEM_ACK
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit: one request/ack bus transaction per access.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module data_mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_READ_EN,
  input  logic                  MEM_WRITE_EN,
  input  logic [2:0]            FUNC3,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSYWAIT,
  output logic                  BUS_ERROR,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  MISALIGNED,
`endif
  data_mem_access_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [7:0] TO = 8'(ACK_TIMEOUT);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic                  wr_q, wr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wd_q, wd_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  berr_q, berr_d;
  logic                  rreq_q, rreq_d;
  logic                  wreq_q, wreq_d;
  logic                  busy;
  logic                  req;
  logic                  mis;
  logic [3:0]            be_n;
  logic [31:0]           wd_n;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                  mis_q, mis_d;
`endif

  assign req = MEM_READ_EN | MEM_WRITE_EN;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = ((FUNC3[1:0] == 2'b01) && ADDRESS[0])
             || ((FUNC3 == 3'b010) && (ADDRESS[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  function automatic logic [31:0] fmt(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      2'd3: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    unique case (f3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b100:  fmt = {24'd0, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b101:  fmt = {16'd0, h};
      default: fmt = d;
    endcase
  endfunction

  // Writes win when both enables are high; reads always enable all lanes.
  always_comb begin
    be_n = 4'b1111;
    wd_n = WRITE_DATA;
    if (MEM_WRITE_EN) begin
      unique case (1'b1)
        (FUNC3 == 3'b000): begin
          be_n = 4'b0001 << ADDRESS[1:0];
          wd_n = {4{WRITE_DATA[7:0]}};
        end
        (FUNC3 == 3'b001): begin
          be_n = 4'b0011 << {ADDRESS[1], 1'b0};
          wd_n = {2{WRITE_DATA[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = WRITE_DATA;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    berr_d  = 1'b0;
    rreq_d  = 1'b0;
    wreq_d  = 1'b0;
    busy    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (mis) begin
            state_d = DONE;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d   = 1'b1;
`endif
          end else begin
            busy    = 1'b1;
            state_d = ACCESS;
            cnt_d   = 8'd0;
            addr_d  = ADDRESS[ADDR_WIDTH-1:2];
            off_d   = ADDRESS[1:0];
            f3_d    = FUNC3;
            wr_d    = MEM_WRITE_EN;
            be_d    = be_n;
            wd_d    = wd_n;
            rreq_d  = ~MEM_WRITE_EN;
            wreq_d  = MEM_WRITE_EN;
          end
        end
      end
      ACCESS: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (mem.MEM_ACK) begin
          state_d = DONE;
          if (!wr_q) rdata_d = fmt(f3_q, off_q, mem.MEM_RDATA);
        end else if ((cnt_q + 8'd1) == TO) begin
          state_d = DONE;
          berr_d  = 1'b1;
          if (!wr_q) rdata_d = 32'd0;
        end else begin
          rreq_d = ~wr_q;
          wreq_d = wr_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      rreq_q  <= rreq_d;
      wreq_q  <= wreq_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign READ_DATA         = rdata_q;
  assign BUSYWAIT          = busy & ~RESET;
  assign BUS_ERROR         = berr_q;
  assign mem.MEM_REQ_READ  = rreq_q;
  assign mem.MEM_REQ_WRITE = wreq_q;
  assign mem.MEM_ADDR      = addr_q;
  assign mem.MEM_WDATA     = wd_q;
  assign mem.MEM_BYTE_EN   = be_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign MISALIGNED        = mis_q;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with ACK_TIMEOUT=4.
// Memory side is driven by hand, one step at a time.
module tb_data_mem_access_unit;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        BUS_ERROR;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MISALIGNED;
`endif

  int checks = 0;
  int errors = 0;
  int busy_total = 0;
  int busy_cnt;
  int b0;
  logic        cap_rq, cap_wq, done_busy;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;

  data_mem_access_unit_if #(.ADDR_WIDTH(32)) mem ();

  data_mem_access_unit #(
    .ADDR_WIDTH (32),
    .ACK_TIMEOUT(4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MEM_READ_EN (MEM_READ_EN),
    .MEM_WRITE_EN(MEM_WRITE_EN),
    .FUNC3       (FUNC3),
    .ADDRESS     (ADDRESS),
    .WRITE_DATA  (WRITE_DATA),
    .READ_DATA   (READ_DATA),
    .BUSYWAIT    (BUSYWAIT),
    .BUS_ERROR   (BUS_ERROR),
`ifdef MEM_MISALIGN_TRAP_EN
    .MISALIGNED  (MISALIGNED),
`endif
    .mem         (mem)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (BUSYWAIT) busy_total++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access, ack it after k ACCESS cycles, return in IDLE.
  task automatic access(input logic re, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int k);
    MEM_READ_EN  = re;
    MEM_WRITE_EN = we;
    FUNC3        = f3;
    ADDRESS      = addr;
    WRITE_DATA   = wd;
    b0 = busy_total;
    tick();
    cap_rq   = mem.MEM_REQ_READ;
    cap_wq   = mem.MEM_REQ_WRITE;
    cap_addr = mem.MEM_ADDR;
    cap_be   = mem.MEM_BYTE_EN;
    cap_wd   = mem.MEM_WDATA;
    repeat (k) tick();
    mem.MEM_ACK   = 1'b1;
    mem.MEM_RDATA = rd;
    tick();
    mem.MEM_ACK   = 1'b0;
    mem.MEM_RDATA = 32'd0;
    done_busy = BUSYWAIT;
    busy_cnt  = busy_total - b0;
    MEM_READ_EN  = 1'b0;
    MEM_WRITE_EN = 1'b0;
    tick();
  endtask

  initial begin
    RESET = 1'b1;
    MEM_READ_EN = 1'b0;
    MEM_WRITE_EN = 1'b0;
    FUNC3 = 3'd0;
    ADDRESS = 32'd0;
    WRITE_DATA = 32'd0;
    mem.MEM_ACK = 1'b0;
    mem.MEM_RDATA = 32'd0;
    tick();
    tick();
    chk("rst_rdata", READ_DATA, 32'd0);
    chk("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_berr", {31'd0, BUS_ERROR}, 32'd0);
    chk("rst_rreq", {31'd0, mem.MEM_REQ_READ}, 32'd0);
    chk("rst_wreq", {31'd0, mem.MEM_REQ_WRITE}, 32'd0);
    chk("rst_addr", {2'd0, mem.MEM_ADDR}, 32'd0);
    chk("rst_be", {28'd0, mem.MEM_BYTE_EN}, 32'd0);
    chk("rst_wd", mem.MEM_WDATA, 32'd0);
    RESET = 1'b0;
    tick();

    // LW 0x104, ack two cycles after the request
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'hDEADBEEF, 2);
    chk("lw_rq", {31'd0, cap_rq}, 32'd1);
    chk("lw_addr", {2'd0, cap_addr}, 32'h41);
    chk("lw_be", {28'd0, cap_be}, 32'hF);
    chk("lw_busy4", busy_cnt, 32'd4);
    chk("lw_done_busy", {31'd0, done_busy}, 32'd0);
    chk("lw_data", READ_DATA, 32'hDEADBEEF);

    // Byte / halfword lanes with zero-wait ack
    access(1'b1, 1'b0, 3'b000, 32'h3, 32'd0, 32'h80112233, 0);
    chk("lb_data", READ_DATA, 32'hFFFFFF80);
    chk("lb_busy2", busy_cnt, 32'd2);
    access(1'b1, 1'b0, 3'b100, 32'h3, 32'd0, 32'h80112233, 0);
    chk("lbu_data", READ_DATA, 32'h00000080);
    access(1'b1, 1'b0, 3'b101, 32'h2, 32'd0, 32'h80112233, 0);
    chk("lhu_data", READ_DATA, 32'h00008011);
    access(1'b1, 1'b0, 3'b001, 32'h2, 32'd0, 32'h80112233, 1);
    chk("lh_data", READ_DATA, 32'hFFFF8011);
    access(1'b1, 1'b0, 3'b000, 32'h1, 32'd0, 32'h80112233, 0);
    chk("lb1_data", READ_DATA, 32'h00000022);

    // Stores
    access(1'b0, 1'b1, 3'b000, 32'h6, 32'h000000A5, 32'd0, 1);
    chk("sb_wq", {31'd0, cap_wq}, 32'd1);
    chk("sb_rq", {31'd0, cap_rq}, 32'd0);
    chk("sb_be", {28'd0, cap_be}, 32'h4);
    chk("sb_wd", cap_wd, 32'hA5A5A5A5);
    chk("sb_addr", {2'd0, cap_addr}, 32'h1);
    chk("sb_rdhold", READ_DATA, 32'h00000022);
    access(1'b0, 1'b1, 3'b001, 32'h2, 32'h1234ABCD, 32'd0, 0);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wd", cap_wd, 32'hABCDABCD);
    access(1'b1, 1'b1, 3'b010, 32'h8, 32'h11223344, 32'hFFFFFFFF, 0);
    chk("both_wq", {31'd0, cap_wq}, 32'd1);
    chk("both_rq", {31'd0, cap_rq}, 32'd0);
    chk("both_be", {28'd0, cap_be}, 32'hF);
    chk("both_wd", cap_wd, 32'h11223344);
    chk("both_rdhold", READ_DATA, 32'h00000022);

    // Load never acked: abort after four ACCESS cycles
    MEM_READ_EN = 1'b1;
    FUNC3 = 3'b010;
    ADDRESS = 32'h10;
    tick();
    repeat (3) tick();
    chk("to_rq4", {31'd0, mem.MEM_REQ_READ}, 32'd1);
    chk("to_berr4", {31'd0, BUS_ERROR}, 32'd0);
    tick();
    chk("to_berr", {31'd0, BUS_ERROR}, 32'd1);
    chk("to_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("to_rdata", READ_DATA, 32'd0);
    chk("to_rq", {31'd0, mem.MEM_REQ_READ}, 32'd0);
    MEM_READ_EN = 1'b0;
    tick();
    chk("to_berr_end", {31'd0, BUS_ERROR}, 32'd0);
    MEM_READ_EN = 1'b1;
    #1;
    chk("to_idle", {31'd0, BUSYWAIT}, 32'd1);
    MEM_READ_EN = 1'b0;
    tick();

    // Reset in the middle of ACCESS, then a stray ack
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 32'h55AA55AA, 0);
    chk("pre_rst_data", READ_DATA, 32'h55AA55AA);
    MEM_READ_EN = 1'b1;
    tick();
    chk("mid_rq", {31'd0, mem.MEM_REQ_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_rq", {31'd0, mem.MEM_REQ_READ}, 32'd0);
    chk("mid_rst_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("mid_rst_data", READ_DATA, 32'd0);
    MEM_READ_EN = 1'b0;
    tick();
    RESET = 1'b0;
    mem.MEM_ACK = 1'b1;
    mem.MEM_RDATA = 32'h12345678;
    tick();
    mem.MEM_ACK = 1'b0;
    chk("late_ack_data", READ_DATA, 32'd0);
    chk("late_ack_rq", {31'd0, mem.MEM_REQ_READ}, 32'd0);
    chk("late_ack_busy", {31'd0, BUSYWAIT}, 32'd0);
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    MEM_READ_EN = 1'b1;
    FUNC3 = 3'b010;
    ADDRESS = 32'h2;
    #1;
    chk("mis_busy", {31'd0, BUSYWAIT}, 32'd0);
    tick();
    chk("mis_flag", {31'd0, MISALIGNED}, 32'd1);
    chk("mis_rq", {31'd0, mem.MEM_REQ_READ}, 32'd0);
    chk("mis_data", READ_DATA, 32'd0);
    MEM_READ_EN = 1'b0;
    tick();
    chk("mis_flag_end", {31'd0, MISALIGNED}, 32'd0);
`else
    access(1'b1, 1'b0, 3'b010, 32'h2, 32'd0, 32'hCAFEF00D, 0);
    chk("lw2_rq", {31'd0, cap_rq}, 32'd1);
    chk("lw2_addr", {2'd0, cap_addr}, 32'd0);
    chk("lw2_data", READ_DATA, 32'hCAFEF00D);
    access(1'b1, 1'b0, 3'b001, 32'h1, 32'd0, 32'h80112233, 0);
    chk("lh1_data", READ_DATA, 32'h00002233);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
